vi_mem_ctrl: RTL and testbench

VI_MEM_CTRL -- requirements
Module: vi_mem_ctrl

---
 rtl/vi_mem_ctrl.sv | 121 ++++++++++++
 tb/tb_vi_mem_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vi_mem_ctrl.sv
// Line-oriented memory controller: fixed-latency 128-bit line reads, word/byte writes at any time.
// Writes landing on the response edge are forwarded into the registered read data.
module vi_mem_ctrl #(
  parameter int LINES = 4096,
  parameter int LAT   = 4
) (
  input  logic         clk_i,
  input  logic         rsn_i,
  input  logic         mem_read_i,
  input  logic [19:0]  mem_read_addr_i,
  input  logic         mem_write_enable_i,
  input  logic         mem_write_byte_i,
  input  logic [19:0]  mem_write_addr_i,
  input  logic [31:0]  mem_write_data_i,
  output logic         mem_data_ready_o,
  output logic [127:0] mem_data_o,
  output logic [19:0]  mem_addr_o
);
  // state  | meaning
  // S_IDLE | waiting for a read request
  // S_WAIT | latency countdown, read inputs ignored
  // S_RESP | next edge registers the line and raises mem_data_ready_o
  // S_HOLD | response cycle, request ignored, back to idle
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  localparam int IW = $clog2(LINES);
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  logic [127:0] mem [LINES];

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [19:0]   lat_addr;
  logic          addr_load;
  logic          resp_fire;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [127:0]  rd_line;
  logic          unused_wr_hi;

  function automatic logic [127:0] merge_write(input logic [127:0] line, input logic byte_wr,
                                               input logic [19:0] addr, input logic [31:0] data);
    logic [127:0] res;
    res = line;
    if (byte_wr) res[{addr[3:0], 3'b000} +: 8] = data[7:0];
    else         res[{addr[3:2], 5'b00000} +: 32] = data;
    return res;
  endfunction

  assign wr_idx       = mem_write_addr_i[IW+3:4];
  assign rd_idx       = lat_addr[IW+3:4];
  assign unused_wr_hi = ^mem_write_addr_i;

  always_ff @(posedge clk_i) begin
    if (rsn_i && mem_write_enable_i)
      mem[wr_idx] <= merge_write(mem[wr_idx], mem_write_byte_i, mem_write_addr_i, mem_write_data_i);
  end

  // The write committing on the same edge as the response must be visible in it.
  always_comb begin
    rd_line = mem[rd_idx];
    if (mem_write_enable_i && (wr_idx == rd_idx))
      rd_line = merge_write(rd_line, mem_write_byte_i, mem_write_addr_i, mem_write_data_i);
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      lat_addr <= 20'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (addr_load) lat_addr <= mem_read_addr_i;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_load = 1'b0;
    resp_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_read_i) begin
          addr_load = 1'b1;
          if (LAT == 1) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_fire = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      mem_data_ready_o <= 1'b0;
      mem_data_o       <= 128'd0;
      mem_addr_o       <= 20'd0;
    end else begin
      mem_data_ready_o <= resp_fire;
      if (resp_fire) begin
        mem_data_o <= rd_line;
        mem_addr_o <= lat_addr;
      end
    end
  end

endmodule

// File: tb/tb_vi_mem_ctrl.sv
// Bench for vi_mem_ctrl: table of write/read vectors scored through a response queue,
// plus sequences for streaming reads, WAIT-time writes, mid-read reset and LAT=1.
module tb_vi_mem_ctrl;
  localparam int LAT = 4;

  logic         clk;
  logic         rsn;
  logic         mem_read;
  logic [19:0]  mem_read_addr;
  logic         mem_we;
  logic         mem_wbyte;
  logic [19:0]  mem_waddr;
  logic [31:0]  mem_wdata;
  logic         ready0, ready1;
  logic [127:0] data0, data1;
  logic [19:0]  addr0, addr1;

  typedef struct {
    int unsigned  cyc;
    logic [19:0]  addr;
    logic [127:0] line;
    logic [127:0] mask;
  } exp_t;

  typedef struct {
    logic        wbyte;
    logic [19:0] waddr;
    logic [31:0] wdata;
    logic [19:0] raddr;
    logic [1:0]  wsel;
    logic [31:0] exp_word;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  vi_mem_ctrl #(.LINES(4096), .LAT(LAT)) dut (
    .clk_i(clk), .rsn_i(rsn), .mem_read_i(mem_read), .mem_read_addr_i(mem_read_addr),
    .mem_write_enable_i(mem_we), .mem_write_byte_i(mem_wbyte), .mem_write_addr_i(mem_waddr),
    .mem_write_data_i(mem_wdata), .mem_data_ready_o(ready0), .mem_data_o(data0), .mem_addr_o(addr0)
  );

  vi_mem_ctrl #(.LINES(4096), .LAT(1)) dut_lat1 (
    .clk_i(clk), .rsn_i(rsn), .mem_read_i(mem_read), .mem_read_addr_i(mem_read_addr),
    .mem_write_enable_i(mem_we), .mem_write_byte_i(mem_wbyte), .mem_write_addr_i(mem_waddr),
    .mem_write_data_i(mem_wdata), .mem_data_ready_o(ready1), .mem_data_o(data1), .mem_addr_o(addr1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ready0 === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: pulse at cycle %0d with no pending read", cyc);
      end else begin
        e = sb.pop_front();
        check("ready_cycle", 128'(cyc), 128'(e.cyc));
        check("resp_addr", 128'(addr0), 128'(e.addr));
        check("resp_data", data0 & e.mask, e.line & e.mask);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_line(input int unsigned c, input logic [19:0] a,
                           input logic [127:0] line, input logic [127:0] mask);
    exp_t e;
    e.cyc  = c;
    e.addr = a;
    e.line = line;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic push_word(input int unsigned c, input logic [19:0] a,
                           input logic [1:0] ws, input logic [31:0] w);
    logic [127:0] line, mask;
    line = 128'(w) << (32 * int'(ws));
    mask = 128'hFFFF_FFFF << (32 * int'(ws));
    push_line(c, a, line, mask);
  endtask

  task automatic do_write(input logic b, input logic [19:0] a, input logic [31:0] d);
    mem_we    = 1'b1;
    mem_wbyte = b;
    mem_waddr = a;
    mem_wdata = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic do_read(input logic [19:0] a, input logic [1:0] ws, input logic [31:0] w);
    mem_read      = 1'b1;
    mem_read_addr = a;
    push_word(cyc + 1 + LAT, a, ws, w);
    tick();
    mem_read = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL response_timeout: %0d responses missing after %0d cycles", sb.size(), n);
      sb.delete();
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int pulses;

    vecs[0] = '{1'b0, 20'h01000, 32'h0031_1133, 20'h01000, 2'd0, 32'h0031_1133};
    vecs[1] = '{1'b0, 20'h02004, 32'hAABB_CCDD, 20'h02004, 2'd1, 32'hAABB_CCDD};
    vecs[2] = '{1'b1, 20'h02006, 32'h0000_0011, 20'h02008, 2'd1, 32'hAA11_CCDD};
    vecs[3] = '{1'b1, 20'h01003, 32'hFFFF_FFEE, 20'h01000, 2'd0, 32'hEE31_1133};
    vecs[4] = '{1'b0, 20'h51010, 32'hCAFE_F00D, 20'h01010, 2'd0, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 20'h0101B, 32'h1357_9BDF, 20'h01018, 2'd2, 32'h1357_9BDF};
    vecs[6] = '{1'b1, 20'h01011, 32'h0000_0077, 20'hF1014, 2'd0, 32'hCAFE_770D};
    vecs[7] = '{1'b0, 20'h0FFFC, 32'h0BAD_C0DE, 20'h0FFF0, 2'd3, 32'h0BAD_C0DE};

    rsn           = 1'b1;
    mem_read      = 1'b0;
    mem_read_addr = 20'd0;
    mem_we        = 1'b0;
    mem_wbyte     = 1'b0;
    mem_waddr     = 20'd0;
    mem_wdata     = 32'd0;

    #3 rsn = 1'b0;
    #1;
    check("reset_ready", 128'(ready0), 128'(0));
    check("reset_data", data0, 128'd0);
    check("reset_addr", 128'(addr0), 128'(0));
    repeat (2) tick();
    rsn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].wbyte, vecs[i].waddr, vecs[i].wdata);
      do_read(vecs[i].raddr, vecs[i].wsel, vecs[i].exp_word);
      drain();
    end

    // write during WAIT plus a write on the response edge itself
    mem_read      = 1'b1;
    mem_read_addr = 20'h08000;
    push_line(cyc + 1 + LAT, 20'h08000,
              {32'hDEAD_BEEF, 32'd0, 32'h0F0F_0F0F, 32'd0},
              {32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'd0});
    tick();
    mem_read = 1'b0;
    do_write(1'b0, 20'h0800C, 32'hDEAD_BEEF);
    repeat (2) tick();
    do_write(1'b0, 20'h08004, 32'h0F0F_0F0F);
    drain();

    // request held high: accepted every LAT+2 cycles
    base          = cyc;
    mem_read      = 1'b1;
    mem_read_addr = 20'h02004;
    for (int k = 0; k < 4; k++)
      push_word(base + 1 + LAT + k * (LAT + 2), 20'h02004, 2'd1, 32'hAA11_CCDD);
    repeat (20) tick();
    mem_read = 1'b0;
    drain();

    // reset two cycles into a pending read; write under reset must be dropped
    mem_read      = 1'b1;
    mem_read_addr = 20'h01000;
    tick();
    mem_read = 1'b0;
    repeat (2) tick();
    rsn = 1'b0;
    #1;
    check("midreset_ready", 128'(ready0), 128'(0));
    check("midreset_data", data0, 128'd0);
    check("midreset_addr", 128'(addr0), 128'(0));
    mem_we    = 1'b1;
    mem_wbyte = 1'b0;
    mem_waddr = 20'h01000;
    mem_wdata = 32'hFFFF_FFFF;
    tick();
    rsn    = 1'b1;
    mem_we = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ready0 === 1'b1) pulses++;
    end
    check("no_ready_after_reset", 128'(pulses), 128'(0));
    do_read(20'h01000, 2'd0, 32'hEE31_1133);
    drain();

    // simultaneous read and write in IDLE, checked on both latencies
    mem_read      = 1'b1;
    mem_read_addr = 20'h00000;
    mem_we        = 1'b1;
    mem_wbyte     = 1'b0;
    mem_waddr     = 20'h00000;
    mem_wdata     = 32'h1234_5678;
    push_word(cyc + 1 + LAT, 20'h00000, 2'd0, 32'h1234_5678);
    tick();
    mem_read = 1'b0;
    mem_we   = 1'b0;
    check("lat1_not_early", 128'(ready1), 128'(0));
    tick();
    check("lat1_ready", 128'(ready1), 128'(1));
    check("lat1_data", 128'(data1[31:0]), 128'h1234_5678);
    check("lat1_addr", 128'(addr1), 128'(0));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
